// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-clocked command decoder for eight 8-bit registers.
// Deserialises MOSI frames (command byte, then data bytes) into register
// writes and pipelined reads. Addresses 0-6 are writable. Address 7 returns
// the live status_in value, and writes to it are dropped. tx_data is the byte
// the slave shifter transmits during the next frame.
module spi_reg_bank #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        cs,
    input  logic        mosi,
    input  logic [7:0]  status_in,
    output logic [7:0]  tx_data,
    output logic        sending,
    output logic [55:0] regs_flat,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic [3:0]  trunc_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  sh_reg;
    logic [2:0]  addr_reg;
    logic [7:0]  tx_data_reg;
    logic        sending_reg;
    logic        wr_strobe_reg;
    logic [2:0]  wr_addr_reg;
    logic [3:0]  trunc_cnt_reg;

    logic [7:0]  regs_mem [0:6];
    logic [7:0]  rd_vec   [0:7];

    logic [7:0]  byte_in;
    logic        byte_done;
    logic        cmd_done;
    logic        wr_commit;
    logic        frame_trunc;
    logic        unused_bits;

    // Byte as it stands once the current MOSI bit is shifted in
    assign byte_in     = {sh_reg[6:0], mosi};
    // The 8th bit of a byte only counts if cs is still low on that edge
    assign byte_done   = !cs && (bit_cnt_reg == 3'd7);
    assign cmd_done    = (state_reg == CMD)   && byte_done;
    assign wr_commit   = (state_reg == WDATA) && byte_done;
    // cs rising mid-byte while receiving command or data loses a partial byte
    assign frame_trunc = cs && ((state_reg == CMD) || (state_reg == WDATA))
                         && (bit_cnt_reg != 3'd0);

    // Reserved command bits and the shifted-out MSB carry no meaning
    assign unused_bits = &{1'b0, sh_reg[7], byte_in[6:3]};

    // Next-state logic: cs high always returns to IDLE
    always_comb begin
        state_next = state_reg;
        if (cs) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = CMD;
                CMD:     if (byte_done) state_next = byte_in[7] ? WDATA : RDONE;
                WDATA:   state_next = WDATA;
                RDONE:   state_next = RDONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge sclk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Bit counter, shift register, address pointer, read data and status outputs
    always_ff @(posedge sclk) begin
        if (rst) begin
            bit_cnt_reg   <= 3'd0;
            sh_reg        <= 8'h00;
            addr_reg      <= 3'd0;
            tx_data_reg   <= 8'h00;
            sending_reg   <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 3'd0;
            trunc_cnt_reg <= 4'd0;
        end else begin
            sending_reg   <= 1'b1;
            wr_strobe_reg <= wr_commit;
            if (cs) begin
                bit_cnt_reg <= 3'd0;
                if (frame_trunc && (trunc_cnt_reg != 4'd15))
                    trunc_cnt_reg <= trunc_cnt_reg + 4'd1;
            end else if (state_reg != RDONE) begin
                // In IDLE the counter is already 0, so the first bit leaves it at 1
                sh_reg      <= byte_in;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            if (cmd_done) begin
                addr_reg <= byte_in[2:0];
                if (!byte_in[7])
                    tx_data_reg <= rd_vec[byte_in[2:0]];
            end
            if (wr_commit) begin
                wr_addr_reg <= addr_reg;
                addr_reg    <= addr_reg + 3'd1;
            end
        end
    end

    // Per-register storage and read mux inputs; slot 7 is the status input
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_regs
            // Register gi loads the completed data byte when addressed
            always_ff @(posedge sclk) begin
                if (rst)
                    regs_mem[gi] <= RST_VAL;
                else if (wr_commit && (addr_reg == 3'(gi)))
                    regs_mem[gi] <= byte_in;
            end
            assign rd_vec[gi]           = regs_mem[gi];
            assign regs_flat[8*gi +: 8] = regs_mem[gi];
        end
    endgenerate
    assign rd_vec[7] = status_in;

    assign tx_data   = tx_data_reg;
    assign sending   = sending_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign trunc_cnt = trunc_cnt_reg;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed testbench for spi_reg_bank: writes, reads, burst wrap, status
// reads, truncation counting and mid-frame reset.
module tb_spi_reg_bank;

    localparam logic [7:0] RV = 8'h3C;

    logic        sclk = 1'b0;
    logic        rst;
    logic        cs;
    logic        mosi;
    logic [7:0]  status_in;
    logic [7:0]  tx_data;
    logic        sending;
    logic [55:0] regs_flat;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [3:0]  trunc_cnt;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    logic [2:0] strobe_addrs [$];
    int base;

    spi_reg_bank #(.RST_VAL(RV)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .cs        (cs),
        .mosi      (mosi),
        .status_in (status_in),
        .tx_data   (tx_data),
        .sending   (sending),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .trunc_cnt (trunc_cnt)
    );

    always #5 sclk = ~sclk;

    // Count strobe samples; a correct one-period pulse is seen exactly once
    always @(negedge sclk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            strobe_addrs.push_back(wr_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int n);
        return regs_flat[8*n +: 8];
    endfunction

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge sclk);
            cs   = 1'b0;
            mosi = b[i];
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic end_frame(input string name);
        @(negedge sclk);
        cs   = 1'b1;
        mosi = 1'b0;
        @(negedge sclk);
        $display("frame %s: tx_data=%h trunc_cnt=%0d strobes=%0d", name, tx_data, trunc_cnt, strobe_cnt);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; mosi = 1'b0; status_in = 8'h00;
        repeat (2) @(negedge sclk);
        chk("rst_regs",    {8'h00, regs_flat}, {8'h00, {7{RV}}});
        chk("rst_tx",      tx_data, 8'h00);
        chk("rst_sending", sending, 1'b0);
        chk("rst_strobe",  wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 3'd0);
        chk("rst_trunc",   trunc_cnt, 4'd0);
        rst = 1'b0;
        @(negedge sclk);
        chk("sending_up", sending, 1'b1);

        // Single write to reg 2
        base = strobe_cnt;
        send_byte(8'h82); send_byte(8'h5A); end_frame("wr2");
        chk("wr2_reg",     reg_at(2), 8'h5A);
        chk("wr2_strobes", strobe_cnt - base, 1);
        chk("wr2_addr",    strobe_addrs[base], 3'd2);
        chk("wr2_tx",      tx_data, 8'h00);

        // Read back reg 2
        send_byte(8'h02); end_frame("rd2");
        chk("rd2_tx", tx_data, 8'h5A);

        // Burst wrap 6 -> 7 (dropped) -> 0
        base = strobe_cnt;
        send_byte(8'h86); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        end_frame("burst");
        chk("burst_reg6",    reg_at(6), 8'h11);
        chk("burst_reg0",    reg_at(0), 8'h33);
        chk("burst_reg1",    reg_at(1), RV);
        chk("burst_strobes", strobe_cnt - base, 3);
        chk("burst_a0",      strobe_addrs[base],     3'd6);
        chk("burst_a1",      strobe_addrs[base + 1], 3'd7);
        chk("burst_a2",      strobe_addrs[base + 2], 3'd0);
        chk("burst_tx_hold", tx_data, 8'h5A);

        // Status reads at address 7
        status_in = 8'hC3;
        send_byte(8'h07); end_frame("rd7");
        chk("rd7_tx", tx_data, 8'hC3);
        base = strobe_cnt;
        send_byte(8'h87); send_byte(8'hFF); end_frame("wr7");
        chk("wr7_strobes", strobe_cnt - base, 1);
        chk("wr7_addr",    strobe_addrs[base], 3'd7);
        chk("wr7_regs",    {8'h00, regs_flat}, {8'h00, 8'h11, RV, RV, RV, 8'h5A, RV, 8'h33});
        send_byte(8'h07); end_frame("rd7b");
        chk("rd7b_tx", tx_data, 8'hC3);
        status_in = 8'h5E;
        send_byte(8'h07); end_frame("rd7c");
        chk("rd7c_tx", tx_data, 8'h5E);
        send_byte(8'h06); end_frame("rd6");
        chk("rd6_tx", tx_data, 8'h11);

        // Truncation: partial data byte
        base = strobe_cnt;
        send_byte(8'h81); send_bits(8'hFF, 5); end_frame("trunc5");
        chk("trunc5_cnt",  trunc_cnt, 4'd1);
        chk("trunc5_reg1", reg_at(1), RV);
        // cs rises on the edge that would complete the byte
        send_byte(8'h81); send_bits(8'hFF, 7); end_frame("trunc7");
        chk("trunc7_cnt",  trunc_cnt, 4'd2);
        chk("trunc7_reg1", reg_at(1), RV);
        chk("trunc_strobes", strobe_cnt - base, 0);
        // Clean frames: write with no data, read with trailing bits
        send_byte(8'h81); end_frame("clean_wr");
        chk("clean_wr_cnt", trunc_cnt, 4'd2);
        send_byte(8'h01); send_bits(8'hA0, 3); end_frame("clean_rd");
        chk("clean_rd_cnt", trunc_cnt, 4'd2);
        chk("clean_rd_tx",  tx_data, RV);
        // Truncated inside the command byte
        send_bits(8'h80, 3); end_frame("trunc_cmd");
        chk("trunc_cmd_cnt", trunc_cnt, 4'd3);
        for (int k = 0; k < 14; k++) begin
            send_bits(8'h80, 2); end_frame("trunc_sat");
        end
        chk("trunc_sat_cnt", trunc_cnt, 4'd15);

        // Reset in the middle of a data byte
        send_byte(8'h84); send_bits(8'hF0, 4);
        @(negedge sclk);
        rst = 1'b1; mosi = 1'b1;
        @(negedge sclk);
        chk("mrst_regs",    {8'h00, regs_flat}, {8'h00, {7{RV}}});
        chk("mrst_tx",      tx_data, 8'h00);
        chk("mrst_sending", sending, 1'b0);
        chk("mrst_trunc",   trunc_cnt, 4'd0);
        rst = 1'b0; cs = 1'b1; mosi = 1'b0;
        @(negedge sclk);
        base = strobe_cnt;
        send_byte(8'h83); send_byte(8'hA5); end_frame("wr3");
        chk("wr3_reg",     reg_at(3), 8'hA5);
        chk("wr3_reg4",    reg_at(4), RV);
        chk("wr3_strobes", strobe_cnt - base, 1);
        chk("wr3_addr",    strobe_addrs[base], 3'd3);
        chk("wr3_sending", sending, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Register-bank command decoder on the SPI slave side, clocked directly by the SPI clock. It deserialises MOSI frames into read/write commands against eight 8-bit registers. It also supplies the parallel `tx_data` byte and `sending` enable that the SPI slave shifter loads at chip-select fall. Read data is pipelined: a read command's data is returned in the first byte of the next frame.

## Interface
- `RST_VAL`, default 8'h00: reset value of writable registers 0-6.
- `sclk`, input, 1: SPI clock from master; all state updates on rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `cs`, input, 1: active-low chip select, sampled on rising `sclk`.
- `mosi`, input, 1: serial data from master, MSB first, sampled on rising `sclk`.
- `status_in`, input, 8: read-only status value, visible at address 7.
- `tx_data`, output, 8: byte for the slave shifter to transmit in the next frame.
- `sending`, output, 1: slave enable; 0 in reset, 1 otherwise.
- `regs_flat`, output, 56: registers 0-6; reg n occupies bits [8n+7:8n].
- `wr_strobe`, output, 1: one-cycle pulse when a register write commits.
- `wr_addr`, output, 3: address of the last committed write.
- `trunc_cnt`, output, 4: saturating count of truncated frames.

## Operation
- Frame layout: command byte, then zero or more data bytes, each MSB first.
- Command byte fields:
  - bit7 `rw`: 1 = write, 0 = read.
  - bits6:3: reserved, ignored.
  - bits2:0: `addr`.
- FSM states:
  - IDLE: wait for frame start.
  - CMD: receiving the command byte.
  - WDATA: receiving write data bytes.
  - RDONE: read command done; remaining bits ignored.
- Transitions:
  - Any rising edge with `cs`=1 forces IDLE and clears the bit counter.
  - IDLE -> CMD on a rising edge with `cs`=0. That edge's `mosi` is command bit7 (bit counter = 1 after it).
  - CMD -> WDATA (`rw`=1) or RDONE (`rw`=0) on the 8th command bit.
- Bit counter: 3 bits, increments on each rising edge with `cs`=0 in CMD/WDATA, wraps 7->0.
- Shift register: 8 bits, `{sh[6:0], mosi}`.
- Write, on the 8th bit of each data byte:
  - Target register at the current address gets `{sh[6:0], mosi}`.
  - `wr_strobe` is set and `wr_addr` gets the address.
  - Address increments mod 8 (7 wraps to 0) for burst writes.
  - A write to address 7 is discarded, but `wr_strobe` still pulses with `wr_addr`=7.
- Read, on the 8th command bit:
  - `tx_data` gets reg[addr], or `status_in` for addr 7.
  - `tx_data` holds until the next read command completes.
  - Writes never alter `tx_data`.
  - Bits after the command byte are ignored in RDONE.
- Truncation:
  - A frame is truncated when `cs` is sampled high in CMD or WDATA with bit counter != 0.
  - Partial bytes are discarded.
  - `trunc_cnt` increments, saturating at 15.
  - Frames ending on a byte boundary (counter = 0) are clean.
- Master requirement: at least one rising `sclk` with `cs`=1 between frames. Without it, consecutive frames merge.

## Timing
- Reset values:
  - `tx_data`=8'h00, `sending`=0, `wr_strobe`=0, `wr_addr`=0, `trunc_cnt`=0.
  - Registers 0-6 = `RST_VAL`; FSM in IDLE; counter and shift register cleared.
- `sending` goes to 1 on the first rising edge with `rst`=0.
- `wr_strobe` is registered:
  - High for exactly one `sclk` period after the edge that commits a byte.
  - Cleared at the next rising edge unless another commit occurs. Back-to-back commits are 8 edges apart, so they always appear as separate pulses.
- Register and `tx_data` updates are visible immediately after the committing edge (latency 1 edge from the last bit).
- Read latency: data from a read in frame N is shifted out in bits 0-7 of frame N+1.
- `rst` mid-frame: the reset values above apply at that edge and any partial write is lost. `rst` has priority over `cs` and `mosi`.
- Simultaneous `cs` rising and a completing bit: the `cs`=1 sample wins. The bit is not taken, so the frame counts as truncated.

## Test plan
- Write reg 2: frame 8'h82, 8'h5A, then `cs` high -> reg2=8'h5A, a single `wr_strobe` pulse with `wr_addr`=2, `tx_data` unchanged at 8'h00.
- Read back: frame 8'h02, then `cs` high -> `tx_data`=8'h5A. Next frame: the slave shifts out 8'h5A on MISO.
- Burst wrap: frame 8'h86, 8'h11, 8'h22, 8'h33 -> reg6=8'h11, reg7 unchanged, reg0=8'h33. Three strobes with `wr_addr` 6, 7, 0.
- Status read: `status_in`=8'hC3, frame 8'h07 -> `tx_data`=8'hC3. Write frame 8'h87, 8'hFF leaves read-back of addr 7 equal to `status_in`.
- Truncation: frame 8'h81 then 5 data bits, then `cs` high -> reg1 unchanged, no strobe, `trunc_cnt`=1. Seventeen truncated frames -> `trunc_cnt`=15.
- Reset mid-frame: `rst` asserted at the 4th bit of a data byte -> all registers=`RST_VAL`, `tx_data`=0, `sending`=0. The next clean write 8'h83, 8'hA5 works normally.
